// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: N-to-1 channel multiplexer with a one-entry registered output.
//
// Optional feature macro: MUX_SCAN_EN
//    defined   : mode=1 selects auto-scan, where an internal counter walks the
//                channels 0..N_CH-1 and captures one per free output slot.
//    undefined : direct select only; the mode port is present but ignored.
//
// Ports
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_data    N_CH packed channels of W bits; channel k at [k*W +: W]
//    sel        requested channel (direct mode)
//    sel_valid  sel is valid this cycle
//    sel_ready  a select is accepted this cycle (low during reset and in scan)
//    mode       0 = direct, 1 = auto-scan (only with MUX_SCAN_EN)
//    out_data   captured channel data (zero for an out-of-range select)
//    out_ch     channel index that produced out_data
//    out_err    captured select was >= N_CH
//    out_valid  output register holds a result
//    out_ready  downstream consumes the result this cycle
module mux_nto1_reg #(
   parameter int unsigned N_CH = 32,
   parameter int unsigned W    = 1,
   localparam int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_CH*W-1:0]   in_data,
   input  logic [SEL_W-1:0]    sel,
   input  logic                sel_valid,
   output logic                sel_ready,
   input  logic                mode,
   output logic [W-1:0]        out_data,
   output logic [SEL_W-1:0]    out_ch,
   output logic                out_err,
   output logic                out_valid,
   input  logic                out_ready
);

   logic             slot_free;
   logic             cap;
   logic [SEL_W-1:0] cap_ch;
   logic [W-1:0]     cap_data;
   logic             cap_err;

   assign slot_free = !out_valid || out_ready;

`ifdef MUX_SCAN_EN
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   logic             mode_q;
   logic [SEL_W-1:0] scan_cnt;
   logic             scan_start;
   logic [SEL_W-1:0] scan_ch;

   // A 0->1 mode edge forces channel 0 even if the counter holds a stale value
   // from an earlier scan period.
   assign scan_start = mode && !mode_q;
   assign scan_ch    = scan_start ? '0 : scan_cnt;

   always_comb begin
      if (mode) begin
         sel_ready = 1'b0;
         cap       = rst_n && slot_free;
         cap_ch    = scan_ch;
      end else begin
         sel_ready = rst_n && slot_free;
         cap       = sel_valid && sel_ready;
         cap_ch    = sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= 1'b0;
         scan_cnt <= '0;
      end else begin
         mode_q <= mode;
         if (mode && cap)
            scan_cnt <= (scan_ch == LAST_CH) ? '0 : scan_ch + SEL_W'(1);
         else if (scan_start)
            scan_cnt <= '0;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = mode;

   always_comb begin
      sel_ready = rst_n && slot_free;
      cap       = sel_valid && sel_ready;
      cap_ch    = sel;
   end
`endif

   // Compare-and-pick rather than a variable part-select so an out-of-range
   // index simply yields zero instead of reading past in_data.
   always_comb begin
      cap_data = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (cap_ch == SEL_W'(k))
            cap_data = in_data[k*W +: W];
      end
   end

   assign cap_err = (32'(cap_ch) >= N_CH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_err   <= 1'b0;
      end else if (cap) begin
         out_valid <= 1'b1;
         out_data  <= cap_data;
         out_ch    <= cap_ch;
         out_err   <= cap_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_nto1_reg.sv
module tb_mux_nto1_reg;

   localparam int unsigned NC = 24;
   localparam int unsigned WD = 8;
   localparam int unsigned SW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NC*WD-1:0]  in_data;
   logic [SW-1:0]     sel;
   logic              sel_valid;
   logic              sel_ready;
   logic              mode;
   logic [WD-1:0]     out_data;
   logic [SW-1:0]     out_ch;
   logic              out_err;
   logic              out_valid;
   logic              out_ready;

   mux_nto1_reg #(.N_CH(NC), .W(WD)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
      .sel_valid(sel_valid), .sel_ready(sel_ready), .mode(mode),
      .out_data(out_data), .out_ch(out_ch), .out_err(out_err),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WD-1:0] d;
      logic [SW-1:0] ch;
      logic          err;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // reference state
   logic m_valid;
   logic m_mode_prev;
   int   m_ptr;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [NC*WD-1:0] rand_data();
      logic [NC*WD-1:0] d;
      for (int i = 0; i < NC*WD/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Predicts the coming edge from the inputs now applied.
   task automatic model_eval();
      bit   scan;
      bit   free;
      bit   cap;
      exp_t e;
      int   c;
`ifdef MUX_SCAN_EN
      scan = mode;
`else
      scan = 1'b0;
`endif
      check("out_valid", out_valid, m_valid);
      free = !m_valid || out_ready;
      check("sel_ready", sel_ready, !scan && free);
      cap = 1'b0;
      if (scan) begin
         if (!m_mode_prev) m_ptr = 0;
         if (free) begin
            e.d = in_data[m_ptr*WD +: WD];
            e.ch = SW'(m_ptr);
            e.err = 1'b0;
            q.push_back(e);
            cap = 1'b1;
            m_ptr = (m_ptr + 1) % NC;
         end
      end else if (sel_valid && free) begin
         c = int'(sel);
         e.d   = (c < NC) ? in_data[c*WD +: WD] : '0;
         e.ch  = sel;
         e.err = (c >= NC);
         q.push_back(e);
         cap = 1'b1;
      end
      m_mode_prev = mode;
      m_valid = cap ? 1'b1 : (out_ready ? 1'b0 : m_valid);
   endtask

   task automatic cycle(input logic v, input logic [SW-1:0] s, input logic m,
                        input logic r, input logic [NC*WD-1:0] d);
      @(posedge clk); #1;
      sel_valid = v; sel = s; mode = m; out_ready = r; in_data = d;
      @(negedge clk); #1;
      model_eval();
   endtask

   // Monitor: pops on each consumption and checks holding under back-pressure.
   initial begin
      exp_t          e;
      logic          held = 1'b0;
      logic [WD-1:0] h_d;
      logic [SW-1:0] h_ch;
      logic          h_err;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", out_valid, 1'b1);
               check("hold_data", out_data, h_d);
               check("hold_ch", out_ch, h_ch);
               check("hold_err", out_err, h_err);
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) check("unexpected_result", 1, 0);
               else begin
                  e = q.pop_front();
                  check("out_data", out_data, e.d);
                  check("out_ch", out_ch, e.ch);
                  check("out_err", out_err, e.err);
               end
            end
            held = out_valid && !out_ready;
            h_d = out_data; h_ch = out_ch; h_err = out_err;
         end
      end
   end

   initial begin
      logic [NC*WD-1:0] d;
      logic             m;
      rst_n = 1'b0; sel = '0; sel_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
      in_data = '0;
      m_valid = 1'b0; m_mode_prev = 1'b0; m_ptr = 0;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_out_err", out_err, 0);
      check("rst_sel_ready", sel_ready, 0);
      rst_n = 1'b1;

      // last and first channel back to back
      d = rand_data();
      cycle(1, 5'd23, 0, 1, d);
      cycle(1, 5'd0, 0, 1, d);
      // out-of-range selects
      cycle(1, 5'd25, 0, 1, rand_data());
      cycle(1, 5'd31, 0, 1, rand_data());
      cycle(0, 5'd0, 0, 1, rand_data());

      // back-pressure for 3 cycles with changing in_data
      cycle(1, 5'd7, 0, 1, rand_data());
      for (int i = 0; i < 3; i++) cycle(1, 5'd9, 0, 0, rand_data());
      cycle(1, 5'd9, 0, 1, rand_data());
      cycle(0, 5'd0, 0, 1, rand_data());

      // mode=1 throughput (scan when enabled, direct otherwise)
      for (int i = 0; i < 30; i++) cycle(1, SW'(i), 1, 1, rand_data());
      cycle(0, 5'd0, 0, 1, rand_data());

      // randomized run
      m = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) m = ~m;
         cycle($urandom_range(0, 3) != 0, SW'($urandom_range(0, 31)), m,
               $urandom_range(0, 3) != 0, rand_data());
      end
      cycle(0, 5'd0, 0, 1, rand_data());
      cycle(0, 5'd0, 0, 1, rand_data());

      // reset during a back-pressured result
      cycle(1, 5'd3, 0, 1, rand_data());
      cycle(0, 5'd0, 0, 0, rand_data());
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      check("arst_out_ch", out_ch, 0);
      check("arst_out_err", out_err, 0);
      check("arst_sel_ready", sel_ready, 0);
      q.delete();
      m_valid = 1'b0; m_mode_prev = 1'b0; m_ptr = 0;
      sel_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
      @(negedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(0, 5'd0, 0, 1, rand_data());
      for (int i = 0; i < 40; i++)
         cycle(1, SW'($urandom_range(0, 31)), 0, $urandom_range(0, 1), rand_data());
      for (int i = 0; i < 3; i++) cycle(0, 5'd0, 0, 1, rand_data());

      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_nto1_reg.md
MUX_NTO1_REG -- requirements
Module: mux_nto1_reg

Interface
REQ-001 Parameter N_CH, default 32: number of input channels, 2..256.
REQ-002 Parameter W, default 1: bits per channel, 1..64.
REQ-003 Local parameter SEL_W = ceil(log2(N_CH)): select width; not overridable.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  N_CH*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 sel  input  SEL_W  requested channel, used in direct mode.
REQ-008 sel_valid  input  1  sel is valid this cycle.
REQ-009 sel_ready  output  1  block accepts a select this cycle.
REQ-010 mode  input  1  0 = direct select, 1 = auto-scan (effective only with MUX_SCAN_EN).
REQ-011 out_data  output  W  registered selected channel data.
REQ-012 out_ch  output  SEL_W  channel index that produced out_data.
REQ-013 out_err  output  1  captured select was out of range (sel >= N_CH).
REQ-014 out_valid  output  1  out_data/out_ch/out_err hold a result.
REQ-015 out_ready  input  1  downstream consumes the result this cycle.

Function
REQ-016 One-entry output register; "slot free" = !out_valid || out_ready.
REQ-017 Direct mode: sel_ready = slot free; capture on sel_valid && sel_ready.
REQ-018 Capture latency exactly 1 cycle: values sampled at edge t appear with out_valid=1 after edge t.
REQ-019 Captured out_data = in_data channel sel as sampled at the capture edge, not tracked afterwards.
REQ-020 sel >= N_CH (possible when N_CH is not a power of two): out_data = 0, out_ch = sel, out_err = 1; otherwise out_err = 0.
REQ-021 Back-pressure: while out_valid && !out_ready, out_data, out_ch and out_err hold stable.
REQ-022 Consume and capture in the same cycle: the new result replaces the old; out_valid stays 1 with no bubble.
REQ-023 Consume with no capture: out_valid falls to 0 on that edge.
REQ-024 Scan mode: sel_ready = 0 and sel/sel_valid are ignored; an internal counter scan_cnt supplies the channel.
REQ-025 Scan mode: on every slot-free cycle, capture channel scan_cnt, then scan_cnt increments; it wraps from N_CH-1 to 0; out_err is always 0.
REQ-026 Transition from mode 0 to mode 1, detected on a registered copy of mode: scan_cnt loads 0, and the first scan capture is channel 0.
REQ-027 Mode change with out_valid=1 and back-pressure: the pending result is held until consumed, and the new mode governs the next capture.
REQ-028 Throughput: with out_ready held at 1, one result per cycle in either mode.

Reset
REQ-029 rst_n low asynchronously forces out_valid=0, out_data=0, out_ch=0, out_err=0, scan_cnt=0, registered mode=0.
REQ-030 During reset, sel_ready = 0.
REQ-031 Reset mid-transaction discards the pending result; no result is emitted after release until a new capture.
REQ-032 Release is synchronised by the user; the first capture is allowed on the first rising edge with rst_n high.

Configuration
REQ-033 Macro MUX_SCAN_EN defined: scan mode, scan_cnt and the mode register are implemented per REQ-024..027.
REQ-034 MUX_SCAN_EN undefined: the mode port remains and is ignored, the block is direct-only, and no scan_cnt logic exists.

Verification
REQ-035 N_CH=32, W=1, in_data=32'h8000_0001; sel=31 then sel=0, out_ready=1 -> out_data=1,1 on consecutive cycles; out_ch=31,0.
REQ-036 N_CH=24, W=8; sel=25 -> out_valid=1, out_err=1, out_data=8'h00, out_ch=25.
REQ-037 Direct mode, out_ready=0 for 3 cycles after the first capture -> sel_ready=0, and outputs stay constant even when in_data changes; the next capture follows the first out_ready=1.
REQ-038 MUX_SCAN_EN, N_CH=4, mode raised to 1, out_ready=1 -> out_ch sequence is 0,1,2,3,0,1 with one result per cycle; sel_ready=0.
REQ-039 rst_n pulsed low during a back-pressured result -> out_valid=0 immediately (asynchronously), and all outputs are 0.
REQ-040 MUX_SCAN_EN undefined, mode=1 -> behaviour is identical to direct mode, and sel_ready follows slot free.
